// File: rtl/cpu_datapath_param.sv
// ---------------------------------------------------------------------------
// cpu_datapath_param
//   Parametrised CPU datapath driven cycle-by-cycle by an external controller.
//   Holds AR/PC (AW bits), DR/IR/TR/AC and an NREG-entry register file
//   (DW bits), an ALU with Z/C/N flags and a request/acknowledge memory port
//   with wait states, a stall output and an acknowledge timeout.
//   All registers share one internal bus. The bus is a one-hot AND-OR mux
//   with no tri-states. Any illegal combination of drivers puts 0 on the bus
//   and sets a sticky bus_err.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   en                step enable (0 freezes the datapath; memory FSM runs)
//   bus_src[6:0]      one-hot bus driver {MEM,AC,R,TR,DRH,DRL,PC}, bit0 = PC
//   r_sel             register-file index for both read and write
//   *_load/*_inc      register strobes; alus selects the ALU operation
//   mem_rd/mem_wr     memory request strobes from the controller
//   mem_ack/mem_rdata memory completion and read data
//   mem_req/mem_we/mem_addr/mem_wdata   memory request side
//   stall             high while a transaction is outstanding
//   mem_err/bus_err   sticky error flags, cleared only by reset
//   instr, ac_q, r_q  IR, AC and R[r_sel]
//   z, c, n           ALU flags
// ---------------------------------------------------------------------------
module cpu_datapath_param #(
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int NREG = 4,
  parameter int TMO  = 15,
  localparam int RSW = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [6:0]     bus_src,
  input  logic [RSW-1:0] r_sel,
  input  logic           ar_load,
  input  logic           ar_inc,
  input  logic           pc_load,
  input  logic           pc_inc,
  input  logic           dr_load,
  input  logic           ir_load,
  input  logic           tr_load,
  input  logic           r_load,
  input  logic           ac_load,
  input  logic           ac_load_r,
  input  logic           z_load,
  input  logic [3:0]     alus,
  input  logic           mem_rd,
  input  logic           mem_wr,
  input  logic           mem_ack,
  input  logic [DW-1:0]  mem_rdata,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           stall,
  output logic           mem_err,
  output logic           bus_err,
  output logic [DW-1:0]  instr,
  output logic [DW-1:0]  ac_q,
  output logic [DW-1:0]  r_q,
  output logic           z,
  output logic           c,
  output logic           n
);

  // Bus source bit positions
  localparam int SRC_PC  = 0;
  localparam int SRC_DRL = 1;
  localparam int SRC_DRH = 2;
  localparam int SRC_TR  = 3;
  localparam int SRC_R   = 4;
  localparam int SRC_AC  = 5;
  localparam int SRC_MEM = 6;

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mem_state_e;

  logic [AW-1:0] ar_q, pc_q;
  logic [DW-1:0] dr_q, ir_q, tr_q, rdata_q;
  logic [DW-1:0] rf_q [NREG];
  mem_state_e    state_q;
  logic [CW-1:0] cnt_q;

  logic [AW-1:0] bus;
  logic          bus_legal;
  logic [DW-1:0] alu_res;
  logic          alu_cout;
  logic          step;

  // Registers only advance on an enabled, non-stalled cycle.
  assign step = en & ~stall;

  // ---------------------------------------------------------------- bus mux
  // Legal: no driver, exactly one driver, or DRH+DRL forming a full address.
  assign bus_legal = ((bus_src & (bus_src - 7'd1)) == 7'd0) ||
                     (bus_src == ((7'd1 << SRC_DRH) | (7'd1 << SRC_DRL)));

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus = '0;
    if (bus_legal) begin
      if (bus_src[SRC_PC])  bus = bus | pc_q;
      if (bus_src[SRC_DRL]) bus[DW-1:0] = bus[DW-1:0] | dr_q;
      if (bus_src[SRC_DRH]) bus[AW-1:DW] = bus[AW-1:DW] | dr_q[AW-DW-1:0];
      if (bus_src[SRC_TR])  bus[DW-1:0] = bus[DW-1:0] | tr_q;
      if (bus_src[SRC_R])   bus[DW-1:0] = bus[DW-1:0] | rf_q[r_sel];
      if (bus_src[SRC_AC])  bus[DW-1:0] = bus[DW-1:0] | ac_q;
      if (bus_src[SRC_MEM]) bus[DW-1:0] = bus[DW-1:0] | rdata_q;
    end
  end

  // -------------------------------------------------------------------- ALU
  always_comb begin
    alu_res  = ac_q;
    alu_cout = 1'b0;
    case (alus)
      4'd0:  alu_res = ac_q;
      4'd1:  {alu_cout, alu_res} = {1'b0, ac_q} + {1'b0, bus[DW-1:0]};
      // Bit DW of the widened difference is the borrow.
      4'd2:  {alu_cout, alu_res} = {1'b0, ac_q} - {1'b0, bus[DW-1:0]};
      4'd3:  {alu_cout, alu_res} = {1'b0, ac_q} + (DW+1)'(1);
      4'd4:  alu_res = '0;
      4'd5:  alu_res = ac_q & bus[DW-1:0];
      4'd6:  alu_res = ac_q | bus[DW-1:0];
      4'd7:  alu_res = ac_q ^ bus[DW-1:0];
      4'd8:  alu_res = ~ac_q;
      4'd9:  begin alu_res = {ac_q[DW-2:0], 1'b0}; alu_cout = ac_q[DW-1]; end
      4'd10: begin alu_res = {1'b0, ac_q[DW-1:1]}; alu_cout = ac_q[0]; end
      default: alu_res = ac_q;
    endcase
  end

  // -------------------------------------------------------- datapath regs
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_q <= '0;
      pc_q <= '0;
      dr_q <= '0;
      ir_q <= '0;
      tr_q <= '0;
      ac_q <= '0;
      z    <= 1'b0;
      c    <= 1'b0;
      n    <= 1'b0;
    end else if (step) begin
      if (ar_load)     ar_q <= bus;
      else if (ar_inc) ar_q <= ar_q + AW'(1);
      if (pc_load)     pc_q <= bus;
      else if (pc_inc) pc_q <= pc_q + AW'(1);
      if (dr_load) dr_q <= bus[DW-1:0];
      if (ir_load) ir_q <= dr_q;
      if (tr_load) tr_q <= dr_q;
      if (ac_load_r)    ac_q <= bus[DW-1:0];
      else if (ac_load) ac_q <= alu_res;
      if (z_load) begin
        z <= (alu_res == '0);
        c <= alu_cout;
        n <= alu_res[DW-1];
      end
    end
  end

  // NOTE: the register file is small and must read back as zero after reset,
  // so it is reset explicitly rather than mapped onto a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (step && r_load) begin
      rf_q[r_sel] <= bus[DW-1:0];
    end
  end

  // Sticky bus-conflict flag, raised the cycle after an illegal driver set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            bus_err <= 1'b0;
    else if (!bus_legal) bus_err <= 1'b1;
  end

  // ------------------------------------------------------------ memory FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            if (mem_rd && mem_wr) begin
              mem_err <= 1'b1;
            end else if (mem_rd) begin
              state_q <= ST_RD_WAIT;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              cnt_q   <= '0;
            end else if (mem_wr) begin
              state_q   <= ST_WR_WAIT;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= bus[DW-1:0];
              cnt_q     <= '0;
            end
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          if (mem_ack) begin
            if (state_q == ST_RD_WAIT) rdata_q <= mem_rdata;
            state_q <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (cnt_q == CW'(TMO - 1)) begin
            // TMO request cycles passed without ack: abandon, keep rdata_q.
            state_q <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign stall    = mem_req;
  assign mem_addr = ar_q;
  assign instr    = ir_q;
  assign r_q      = rf_q[r_sel];

endmodule

// File: tb/tb_cpu_datapath_param.sv
// ---------------------------------------------------------------------------
// tb_cpu_datapath_param
//   Directed bench for cpu_datapath_param (DW=8, AW=16, NREG=4, TMO=15).
//   Constants reach the datapath through memory reads (MEM -> bus), since
//   the datapath has no immediate source. Inputs change #1 after the rising
//   edge; outputs are checked at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_cpu_datapath_param;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NREG = 4;
  localparam int TMO = 15;
  localparam int RSW = 2;

  localparam logic [6:0] S_PC  = 7'h01;
  localparam logic [6:0] S_DRL = 7'h02;
  localparam logic [6:0] S_DRH = 7'h04;
  localparam logic [6:0] S_AC  = 7'h20;
  localparam logic [6:0] S_MEM = 7'h40;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [6:0]     bus_src;
  logic [RSW-1:0] r_sel;
  logic ar_load, ar_inc, pc_load, pc_inc, dr_load, ir_load, tr_load;
  logic r_load, ac_load, ac_load_r, z_load;
  logic [3:0]     alus;
  logic           mem_rd, mem_wr, mem_ack;
  logic [DW-1:0]  mem_rdata;
  logic           mem_req, mem_we, stall, mem_err, bus_err;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, instr, ac_q, r_q;
  logic           z, c, n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_datapath_param #(.DW(DW), .AW(AW), .NREG(NREG), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .bus_src(bus_src), .r_sel(r_sel),
    .ar_load(ar_load), .ar_inc(ar_inc), .pc_load(pc_load), .pc_inc(pc_inc),
    .dr_load(dr_load), .ir_load(ir_load), .tr_load(tr_load), .r_load(r_load),
    .ac_load(ac_load), .ac_load_r(ac_load_r), .z_load(z_load), .alus(alus),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .stall(stall), .mem_err(mem_err), .bus_err(bus_err),
    .instr(instr), .ac_q(ac_q), .r_q(r_q), .z(z), .c(c), .n(n)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_src = '0; r_sel = '0; alus = '0;
    ar_load = 0; ar_inc = 0; pc_load = 0; pc_inc = 0; dr_load = 0;
    ir_load = 0; tr_load = 0; r_load = 0; ac_load = 0; ac_load_r = 0;
    z_load = 0; mem_rd = 0; mem_wr = 0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read with ack on the nwait-th request cycle; leaves val in rdata_q.
  task automatic mem_read(input logic [DW-1:0] val, input int nwait);
    mem_rd = 1; tick(); mem_rd = 0;
    for (int i = 1; i <= nwait; i++) begin
      if (i == nwait) begin mem_ack = 1; mem_rdata = val; end
      tick();
      mem_ack = 0;
    end
  endtask

  // Fetch a constant through memory into DR.
  task automatic load_dr(input logic [DW-1:0] val);
    mem_read(val, 1);
    bus_src = S_MEM; dr_load = 1; tick(); idle_inputs();
  endtask

  // Load AR from the given bus sources.
  task automatic load_ar(input logic [6:0] src);
    bus_src = src; ar_load = 1; tick(); idle_inputs();
  endtask

  // One ALU step with z_load; AC takes the result when ac_ld is set.
  task automatic alu_op(input logic [3:0] op, input logic [6:0] src,
                        input logic ac_ld);
    bus_src = src; alus = op; ac_load = ac_ld; z_load = 1; tick(); idle_inputs();
  endtask

  int cycles;

  initial begin
    idle_inputs();
    en = 1; rst = 0;
    tick(); tick();
    rst = 1;
    tick();

    // ---- reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_ac", ac_q, 0);
    check("rst_instr", instr, 0);
    check("rst_flags", {z, c, n, mem_err, bus_err}, 0);

    // ---- DRH/DRL addressing
    load_dr(8'h12);
    load_ar(S_DRH | S_DRL);
    check("ar_drh_drl", mem_addr, 16'h1212);
    load_ar(S_DRH);
    check("ar_drh", mem_addr, 16'h1200);
    load_ar(S_DRL);
    check("ar_drl", mem_addr, 16'h0012);
    load_dr(8'hFF);
    load_ar(S_DRH | S_DRL);
    check("ar_ffff", mem_addr, 16'hFFFF);
    ar_inc = 1; tick(); idle_inputs();
    check("ar_wrap", mem_addr, 16'h0000);
    load_dr(8'h10);
    bus_src = S_DRL; ar_load = 1; ar_inc = 1; tick(); idle_inputs();
    check("ar_load_beats_inc", mem_addr, 16'h0010);
    ir_load = 1; tick(); idle_inputs();
    check("ir_load", instr, 8'h10);
    en = 0; ar_inc = 1; tick(); idle_inputs(); en = 1;
    check("en_freeze", mem_addr, 16'h0010);

    // ---- ALU
    mem_read(8'hFF, 1);
    bus_src = S_MEM; ac_load_r = 1; tick(); idle_inputs();
    check("ac_ff", ac_q, 8'hFF);
    mem_read(8'h01, 1);
    alu_op(4'd1, S_MEM, 1);
    check("add_res", ac_q, 8'h00);
    check("add_zcn", {z, c, n}, 3'b110);
    alu_op(4'd2, S_MEM, 1);
    check("sub_res", ac_q, 8'hFF);
    check("sub_zcn", {z, c, n}, 3'b011);
    alu_op(4'd9, 7'h00, 1);
    check("shl", {ac_q, z, c, n}, {8'hFE, 3'b011});
    alu_op(4'd10, 7'h00, 1);
    check("shr", {ac_q, z, c, n}, {8'h7F, 3'b000});
    alu_op(4'd7, S_MEM, 1);
    check("xor", {ac_q, z, c, n}, {8'h7E, 3'b000});
    alu_op(4'd4, 7'h00, 0);
    check("clr_flags_only", {ac_q, z, c, n}, {8'h7E, 3'b100});

    // ---- read with 3 wait cycles, pc_inc ignored while stalled
    load_dr(8'h40);
    load_ar(S_DRL);
    check("ar_40", mem_addr, 16'h0040);
    mem_rd = 1; tick(); mem_rd = 0;
    pc_inc = 1;
    cycles = 0;
    for (int i = 1; i <= 3; i++) begin
      if (stall) cycles++;
      check("rd_addr_frozen", mem_addr, 16'h0040);
      if (i == 3) begin mem_ack = 1; mem_rdata = 8'hA5; end
      tick();
      mem_ack = 0;
    end
    idle_inputs();
    check("rd_stall_cycles", cycles, 3);
    check("rd_stall_drop", stall, 0);
    bus_src = S_MEM; r_sel = 2; r_load = 1; tick(); idle_inputs();
    r_sel = 2; #1;
    check("r2_a5", r_q, 8'hA5);
    r_sel = 1; #1;
    check("r1_untouched", r_q, 8'h00);
    load_ar(S_PC);
    check("pc_not_inc", mem_addr, 16'h0000);
    pc_inc = 1; tick(); idle_inputs();
    load_ar(S_PC);
    check("pc_inc", mem_addr, 16'h0001);

    // ---- write timeout
    bus_src = S_AC; mem_wr = 1; tick(); idle_inputs();
    check("wr_we", mem_we, 1);
    check("wr_wdata", mem_wdata, 8'h7E);
    cycles = 0;
    while (mem_req && cycles < 40) begin cycles++; tick(); end
    check("tmo_cycles", cycles, TMO);
    check("tmo_err", mem_err, 1);
    tick();
    check("tmo_err_sticky", mem_err, 1);

    // ---- bus conflict (PC=1, AC=0x7E)
    bus_src = S_PC | S_AC; ac_load_r = 1;
    #1;
    check("conflict_err_pre", bus_err, 0);
    tick(); idle_inputs();
    check("conflict_err", bus_err, 1);
    check("conflict_ac", ac_q, 8'h00);

    // ---- reset mid-transaction
    mem_rd = 1; tick(); mem_rd = 0;
    check("mid_req", mem_req, 1);
    #2 rst = 0;
    #1;
    check("rst_mid_req", {mem_req, stall, mem_we}, 0);
    check("rst_mid_err", {mem_err, bus_err}, 0);
    check("rst_mid_regs", {mem_addr, ac_q, instr, r_q, z, c, n}, 0);
    tick();
    rst = 1;
    tick();

    // ---- rd+wr together
    mem_rd = 1; mem_wr = 1; tick(); idle_inputs();
    check("both_no_req", mem_req, 0);
    check("both_err", mem_err, 1);
    mem_ack = 1; tick(); idle_inputs();
    check("idle_ack_ignored", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
